regfile_port_master: RTL and testbench
======================================

# regfile_port_master

Command-driven master for the 4-entry x 8-bit register file. Accepts write, read, dual-read and copy commands over a valid/ready command channel, sequences the register file's write port and two combinational read ports, and returns read results over a valid/ready response channel. Sits between a host/sequencer and the register file so that only one agent ever drives its ports.

## Interface
- DATA_W, 8, register data width
- ADDR_W, 2, register address width (2^ADDR_W entries)
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  2  00 WRITE, 01 READ, 10 READ2, 11 COPY
- cmd_addr_a  in  ADDR_W  WRITE/READ/READ2 first address; COPY source
- cmd_addr_b  in  ADDR_W  READ2 second address; COPY destination
- cmd_data  in  DATA_W  WRITE data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_data_a  out  DATA_W  first read result
- rsp_data_b  out  DATA_W  second read result
- busy  out  1  high whenever state is not IDLE
- done_cnt  out  8  completed-command counter, wraps 255 -> 0
- rf_we  out  1  register file write enable
- rf_wr_addr  out  ADDR_W  register file write address
- rf_wr_data  out  DATA_W  register file write data
- rf_rd_addr1, rf_rd_addr2  out  ADDR_W  register file read addresses
- rf_rd_data1, rf_rd_data2  in  DATA_W  register file read data (combinational)

## Operation
- States: IDLE, WRITE, READ, COPY_RD, COPY_WR, RESP.
- IDLE: cmd_ready=1. Accept on cmd_valid&cmd_ready: latch op, addresses, data; rf_rd_addr1<=cmd_addr_a, rf_rd_addr2<=(READ ? cmd_addr_a : cmd_addr_b); next state WRITE (op 00), READ (01/10), COPY_RD (11).
- WRITE: rf_we=1, rf_wr_addr=addr_a, rf_wr_data=data; -> IDLE; done_cnt+1. No response.
- READ: at cycle end capture rsp_data_a<=rf_rd_data1, rsp_data_b<=rf_rd_data2; -> RESP. For op READ, rsp_data_b equals rsp_data_a.
- COPY_RD: capture rsp_data_a<=regs[src], rsp_data_b<=regs[dst] (old value); -> COPY_WR.
- COPY_WR: rf_we=1, rf_wr_addr=dst, rf_wr_data=rsp_data_a; -> RESP. src==dst legal: writes same value back.
- RESP: rsp_valid=1; rsp_data_a/b stable until handshake; on rsp_ready -> IDLE, done_cnt+1.
- rf_we asserted only in WRITE and COPY_WR, gated by rst_n: no write commits in any cycle with rst_n low.
- rf_wr_addr/rf_wr_data/rf_rd_addr* hold last value outside active states.
- cmd_ready low in all states except IDLE, and low while rst_n low.

## Timing
- Reset (rst_n low at edge): state IDLE; rsp_valid=0, rsp_data_a/b=0, rf_we=0, rf_wr_addr=0, rf_wr_data=0, rf_rd_addr1/2=0, busy=0, done_cnt=0.
- Reset mid-operation: command aborted, no response, no pending write; cmd_ready=1 first cycle after rst_n returns high.
- WRITE: accept edge T; rf_we high cycle T+1; data in register file after edge ending T+1; cmd_ready high cycle T+2.
- READ/READ2: accept T; capture end of T+1; rsp_valid from T+2; earliest next accept T+3 (rsp_ready high in T+2).
- COPY: accept T; rf_we high T+2; rsp_valid from T+3.
- Back-to-back: a READ accepted immediately after a WRITE to the same address returns the new value.
- Response backpressure: rsp_valid held with unchanged data indefinitely while rsp_ready low; cmd_ready stays low.
- done_cnt increments once per completed command, on the completing edge; 255 -> 0.

## Test plan
- Reset, then WRITE 0<-AA, 1<-55, 2<-CC back-to-back -> rf_we one cycle each, cmd_ready gaps of exactly one cycle, done_cnt=3.
- READ2 a=0 b=1 -> rsp_valid at T+2 with rsp_data_a=AA, rsp_data_b=55; READ a=2 -> both CC.
- COPY src=0 dst=1 -> rsp_data_a=AA, rsp_data_b=55 (old); following READ 1 -> AA.
- READ2 with rsp_ready low 3 cycles -> rsp_valid and data held, cmd_ready low, completes on 4th cycle.
- Assert rst_n low in COPY_RD after COPY 2->3 -> no rf_we, no response, all outputs at reset values; register 3 unchanged.
- 256 WRITE commands -> done_cnt wraps to 0.

Source files
------------

// File: rtl/regfile_port_master.sv
// Command-driven master for a small register file: sequences one write port and two
// combinational read ports from write/read/dual-read/copy commands, returning reads on a response channel.
module regfile_port_master #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr_a,
   input  logic [ADDR_W-1:0] cmd_addr_b,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data_a,
   output logic [DATA_W-1:0] rsp_data_b,
   output logic              busy,
   output logic [7:0]        done_cnt,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_wr_addr,
   output logic [DATA_W-1:0] rf_wr_data,
   output logic [ADDR_W-1:0] rf_rd_addr1,
   output logic [ADDR_W-1:0] rf_rd_addr2,
   input  logic [DATA_W-1:0] rf_rd_data1,
   input  logic [DATA_W-1:0] rf_rd_data2
);

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_READ  = 2'b01;
   localparam logic [1:0] OP_COPY  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_COPY_RD,
      S_COPY_WR,
      S_RESP
   } state_t;

   state_t              r_state;
   logic [DATA_W-1:0]   r_rsp_data_a;
   logic [DATA_W-1:0]   r_rsp_data_b;
   logic [ADDR_W-1:0]   r_wr_addr;
   logic [DATA_W-1:0]   r_wr_data;
   logic [ADDR_W-1:0]   r_rd_addr1;
   logic [ADDR_W-1:0]   r_rd_addr2;
   logic [7:0]          r_done_cnt;
   logic                w_idle;
   logic                w_wr_state;

   assign w_idle     = (r_state == S_IDLE);
   assign w_wr_state = (r_state == S_WRITE) || (r_state == S_COPY_WR);

   // Both handshake-facing strobes are masked by reset so nothing is accepted or committed while it is low.
   assign cmd_ready   = rst_n & w_idle;
   assign rf_we       = rst_n & w_wr_state;
   assign rsp_valid   = (r_state == S_RESP);
   assign busy        = !w_idle;
   assign rsp_data_a  = r_rsp_data_a;
   assign rsp_data_b  = r_rsp_data_b;
   assign done_cnt    = r_done_cnt;
   assign rf_wr_addr  = r_wr_addr;
   assign rf_wr_data  = r_wr_data;
   assign rf_rd_addr1 = r_rd_addr1;
   assign rf_rd_addr2 = r_rd_addr2;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_rsp_data_a <= '0;
         r_rsp_data_b <= '0;
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
         r_rd_addr1   <= '0;
         r_rd_addr2   <= '0;
         r_done_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_rd_addr1 <= cmd_addr_a;
                  r_rd_addr2 <= (cmd_op == OP_READ) ? cmd_addr_a : cmd_addr_b;
                  if (cmd_op == OP_WRITE) begin
                     r_wr_addr <= cmd_addr_a;
                     r_wr_data <= cmd_data;
                     r_state   <= S_WRITE;
                  end else if (cmd_op == OP_COPY) begin
                     r_state   <= S_COPY_RD;
                  end else begin
                     r_state   <= S_READ;
                  end
               end
            end
            S_WRITE: begin
               r_done_cnt <= r_done_cnt + 8'd1;
               r_state    <= S_IDLE;
            end
            S_READ: begin
               r_rsp_data_a <= rf_rd_data1;
               r_rsp_data_b <= rf_rd_data2;
               r_state      <= S_RESP;
            end
            S_COPY_RD: begin
               // Read port 2 already points at the destination, so its old value is reported too.
               r_rsp_data_a <= rf_rd_data1;
               r_rsp_data_b <= rf_rd_data2;
               r_wr_addr    <= r_rd_addr2;
               r_wr_data    <= rf_rd_data1;
               r_state      <= S_COPY_WR;
            end
            S_COPY_WR: begin
               r_state <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_done_cnt <= r_done_cnt + 8'd1;
                  r_state    <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_port_master.sv
// Directed bench for regfile_port_master with a behavioural 4x8 register file attached.
module tb_regfile_port_master;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [1:0] cmd_addr_a;
   logic [1:0] cmd_addr_b;
   logic [7:0] cmd_data;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data_a;
   logic [7:0] rsp_data_b;
   logic       busy;
   logic [7:0] done_cnt;
   logic       rf_we;
   logic [1:0] rf_wr_addr;
   logic [7:0] rf_wr_data;
   logic [1:0] rf_rd_addr1;
   logic [1:0] rf_rd_addr2;
   logic [7:0] rf_rd_data1;
   logic [7:0] rf_rd_data2;

   logic [7:0] rf_mem [4] = '{8'h00, 8'h00, 8'h00, 8'h00};

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (rf_we) rf_mem[rf_wr_addr] <= rf_wr_data;
   assign rf_rd_data1 = rf_mem[rf_rd_addr1];
   assign rf_rd_data2 = rf_mem[rf_rd_addr2];

   regfile_port_master #(.DATA_W(8), .ADDR_W(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b),
      .busy(busy), .done_cnt(done_cnt),
      .rf_we(rf_we), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
      .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
      .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one command in an IDLE cycle; returns in the cycle after the accept edge.
   task automatic send_cmd(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b, input logic [7:0] d);
      cmd_valid = 1'b1; cmd_op = op; cmd_addr_a = a; cmd_addr_b = b; cmd_data = d;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
      cmd_op = 2'b00; cmd_addr_a = 2'd0; cmd_addr_b = 2'd0; cmd_data = 8'h00;
      tick(); tick();
      vec_cnt++; if (cmd_ready !== 1'b0) begin err_cnt++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
      vec_cnt++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || rf_we !== 1'b0) begin err_cnt++; $display("FAIL rst_ctrl: got valid=%b busy=%b we=%b want 0 0 0", rsp_valid, busy, rf_we); end
      vec_cnt++; if ({rsp_data_a, rsp_data_b, done_cnt, rf_wr_data} !== 32'h0) begin err_cnt++; $display("FAIL rst_data: got a=%h b=%h cnt=%h wd=%h want all 0", rsp_data_a, rsp_data_b, done_cnt, rf_wr_data); end
      vec_cnt++; if ({rf_wr_addr, rf_rd_addr1, rf_rd_addr2} !== 6'h0) begin err_cnt++; $display("FAIL rst_addr: got %h %h %h want 0 0 0", rf_wr_addr, rf_rd_addr1, rf_rd_addr2); end
      rst_n = 1'b1;
      #1;
      vec_cnt++; if (cmd_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_release_ready: got %b want 1", cmd_ready); end
   endtask

   task automatic test_write_b2b();
      logic [7:0] wd [3] = '{8'hAA, 8'h55, 8'hCC};
      for (int i = 0; i < 3; i++) begin
         send_cmd(2'b00, 2'(i), 2'd0, wd[i]);
         vec_cnt++; if (rf_we !== 1'b1 || rf_wr_addr !== 2'(i) || rf_wr_data !== wd[i]) begin err_cnt++; $display("FAIL wr%0d_port: got we=%b a=%0d d=%h want 1 %0d %h", i, rf_we, rf_wr_addr, rf_wr_data, i, wd[i]); end
         vec_cnt++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin err_cnt++; $display("FAIL wr%0d_gap: got ready=%b busy=%b want 0 1", i, cmd_ready, busy); end
         tick();
         vec_cnt++; if (rf_we !== 1'b0 || cmd_ready !== 1'b1) begin err_cnt++; $display("FAIL wr%0d_done: got we=%b ready=%b want 0 1", i, rf_we, cmd_ready); end
      end
      vec_cnt++; if (done_cnt !== 8'd3) begin err_cnt++; $display("FAIL wr_cnt: got %0d want 3", done_cnt); end
      vec_cnt++; if (rf_mem[0] !== 8'hAA || rf_mem[1] !== 8'h55 || rf_mem[2] !== 8'hCC) begin err_cnt++; $display("FAIL wr_mem: got %h %h %h want aa 55 cc", rf_mem[0], rf_mem[1], rf_mem[2]); end
   endtask

   task automatic test_read();
      send_cmd(2'b10, 2'd0, 2'd1, 8'h00);
      vec_cnt++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin err_cnt++; $display("FAIL rd2_t1: got valid=%b busy=%b want 0 1", rsp_valid, busy); end
      tick();
      vec_cnt++; if (rsp_valid !== 1'b1 || rsp_data_a !== 8'hAA || rsp_data_b !== 8'h55) begin err_cnt++; $display("FAIL rd2_rsp: got v=%b a=%h b=%h want 1 aa 55", rsp_valid, rsp_data_a, rsp_data_b); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      vec_cnt++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || done_cnt !== 8'd4) begin err_cnt++; $display("FAIL rd2_done: got v=%b ready=%b cnt=%0d want 0 1 4", rsp_valid, cmd_ready, done_cnt); end
      send_cmd(2'b01, 2'd2, 2'd3, 8'h00);
      tick();
      vec_cnt++; if (rsp_valid !== 1'b1 || rsp_data_a !== 8'hCC || rsp_data_b !== 8'hCC) begin err_cnt++; $display("FAIL rd1_rsp: got v=%b a=%h b=%h want 1 cc cc", rsp_valid, rsp_data_a, rsp_data_b); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      vec_cnt++; if (done_cnt !== 8'd5) begin err_cnt++; $display("FAIL rd1_cnt: got %0d want 5", done_cnt); end
   endtask

   task automatic test_copy();
      send_cmd(2'b11, 2'd0, 2'd1, 8'h00);
      vec_cnt++; if (rf_we !== 1'b0 || rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL cp_t1: got we=%b v=%b want 0 0", rf_we, rsp_valid); end
      tick();
      vec_cnt++; if (rf_we !== 1'b1 || rf_wr_addr !== 2'd1 || rf_wr_data !== 8'hAA || rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL cp_t2: got we=%b a=%0d d=%h v=%b want 1 1 aa 0", rf_we, rf_wr_addr, rf_wr_data, rsp_valid); end
      tick();
      vec_cnt++; if (rsp_valid !== 1'b1 || rsp_data_a !== 8'hAA || rsp_data_b !== 8'h55 || rf_we !== 1'b0) begin err_cnt++; $display("FAIL cp_rsp: got v=%b a=%h b=%h we=%b want 1 aa 55 0", rsp_valid, rsp_data_a, rsp_data_b, rf_we); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      send_cmd(2'b01, 2'd1, 2'd0, 8'h00);
      tick();
      vec_cnt++; if (rsp_valid !== 1'b1 || rsp_data_a !== 8'hAA || rsp_data_b !== 8'hAA) begin err_cnt++; $display("FAIL cp_readback: got v=%b a=%h b=%h want 1 aa aa", rsp_valid, rsp_data_a, rsp_data_b); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      vec_cnt++; if (done_cnt !== 8'd7) begin err_cnt++; $display("FAIL cp_cnt: got %0d want 7", done_cnt); end
   endtask

   task automatic test_back_to_back();
      send_cmd(2'b00, 2'd3, 2'd0, 8'h3C);
      tick();
      send_cmd(2'b01, 2'd3, 2'd0, 8'h00);
      tick();
      vec_cnt++; if (rsp_valid !== 1'b1 || rsp_data_a !== 8'h3C) begin err_cnt++; $display("FAIL b2b_raw: got v=%b a=%h want 1 3c", rsp_valid, rsp_data_a); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      send_cmd(2'b00, 2'd3, 2'd0, 8'h00);
      tick();
      vec_cnt++; if (done_cnt !== 8'd10 || rf_mem[3] !== 8'h00) begin err_cnt++; $display("FAIL b2b_end: got cnt=%0d r3=%h want 10 00", done_cnt, rf_mem[3]); end
   endtask

   task automatic test_backpressure();
      send_cmd(2'b10, 2'd1, 2'd2, 8'h00);
      tick();
      for (int c = 0; c < 3; c++) begin
         vec_cnt++; if (rsp_valid !== 1'b1 || rsp_data_a !== 8'hAA || rsp_data_b !== 8'hCC || cmd_ready !== 1'b0) begin err_cnt++; $display("FAIL bp_hold%0d: got v=%b a=%h b=%h ready=%b want 1 aa cc 0", c, rsp_valid, rsp_data_a, rsp_data_b, cmd_ready); end
         tick();
      end
      vec_cnt++; if (rsp_valid !== 1'b1 || rsp_data_a !== 8'hAA || done_cnt !== 8'd10) begin err_cnt++; $display("FAIL bp_4th: got v=%b a=%h cnt=%0d want 1 aa 10", rsp_valid, rsp_data_a, done_cnt); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      vec_cnt++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || done_cnt !== 8'd11) begin err_cnt++; $display("FAIL bp_done: got v=%b ready=%b cnt=%0d want 0 1 11", rsp_valid, cmd_ready, done_cnt); end
   endtask

   task automatic test_reset_mid();
      send_cmd(2'b00, 2'd2, 2'd0, 8'h00);
      tick();
      send_cmd(2'b00, 2'd2, 2'd0, 8'hCC);
      tick();
      send_cmd(2'b11, 2'd2, 2'd3, 8'h00);
      rst_n = 1'b0;
      #1;
      vec_cnt++; if (rf_we !== 1'b0 || cmd_ready !== 1'b0) begin err_cnt++; $display("FAIL rm_low: got we=%b ready=%b want 0 0", rf_we, cmd_ready); end
      tick();
      vec_cnt++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || done_cnt !== 8'd0 || rsp_data_a !== 8'h00 || rf_wr_data !== 8'h00) begin err_cnt++; $display("FAIL rm_state: got busy=%b v=%b cnt=%0d a=%h wd=%h want 0 0 0 00 00", busy, rsp_valid, done_cnt, rsp_data_a, rf_wr_data); end
      rst_n = 1'b1;
      #1;
      vec_cnt++; if (cmd_ready !== 1'b1) begin err_cnt++; $display("FAIL rm_ready: got %b want 1", cmd_ready); end
      for (int c = 0; c < 3; c++) begin
         tick();
         vec_cnt++; if (rf_we !== 1'b0 || rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL rm_quiet%0d: got we=%b v=%b want 0 0", c, rf_we, rsp_valid); end
      end
      vec_cnt++; if (rf_mem[3] !== 8'h00) begin err_cnt++; $display("FAIL rm_r3: got %h want 00", rf_mem[3]); end
      // Reset landing on the single write cycle must suppress the commit.
      send_cmd(2'b00, 2'd0, 2'd0, 8'h11);
      rst_n = 1'b0;
      #1;
      vec_cnt++; if (rf_we !== 1'b0) begin err_cnt++; $display("FAIL rm_wr_we: got %b want 0", rf_we); end
      tick();
      rst_n = 1'b1;
      vec_cnt++; if (rf_mem[0] !== 8'hAA) begin err_cnt++; $display("FAIL rm_wr_mem: got %h want aa", rf_mem[0]); end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 256; i++) begin
         send_cmd(2'b00, 2'(i), 2'd0, 8'(i));
         tick();
         if (i == 254) begin
            vec_cnt++; if (done_cnt !== 8'd255) begin err_cnt++; $display("FAIL wrap_255: got %0d want 255", done_cnt); end
         end
      end
      vec_cnt++; if (done_cnt !== 8'd0) begin err_cnt++; $display("FAIL wrap_0: got %0d want 0", done_cnt); end
      vec_cnt++; if (rf_mem[0] !== 8'hFC || rf_mem[3] !== 8'hFF) begin err_cnt++; $display("FAIL wrap_mem: got %h %h want fc ff", rf_mem[0], rf_mem[3]); end
   endtask

   initial begin
      test_reset();
      test_write_b2b();
      test_read();
      test_copy();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
